// File: rtl/tl_phase_sched.sv
// ---------------------------------------------------------------------------
// tl_phase_sched
// Timed phase scheduler for a two-street intersection with protected left
// turns. Sensor pulses are latched as pending demand; the intersection is
// handed to the other street (or to a left turn) only when someone is
// waiting. Min/max green timers bound how long a straight green is held.
//
// Ports
//   clk      in   1      system clock, rising edge
//   reset_n  in   1      synchronous active-low reset
//   Ta       in   1      car present, street A straight
//   Tal      in   1      car present, street A left lane
//   Tb       in   1      car present, street B straight
//   Tbl      in   1      car present, street B left lane
//   La       out  2      street A head: 00 green, 01 yellow, 10 red, 11 left
//   Lb       out  2      street B head: same encoding
//   phase    out  4      current state code (debug)
//   tmr      out  CNT_W  current phase timer (debug)
// ---------------------------------------------------------------------------
module tl_phase_sched #(
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_GREEN = 10,
    parameter int unsigned YELLOW    = 2,
    parameter int unsigned LEFT_TIME = 3,
    parameter int unsigned ALL_RED   = 1,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Ta,
    input  logic             Tal,
    input  logic             Tb,
    input  logic             Tbl,
    output logic [1:0]       La,
    output logic [1:0]       Lb,
    output logic [3:0]       phase,
    output logic [CNT_W-1:0] tmr
);

    // State codes are externally visible on phase, so they are fixed values.
    localparam logic [3:0] S_AG  = 4'd0;
    localparam logic [3:0] S_AY  = 4'd1;
    localparam logic [3:0] S_AL  = 4'd2;
    localparam logic [3:0] S_ALY = 4'd3;
    localparam logic [3:0] S_RAB = 4'd4;
    localparam logic [3:0] S_BG  = 4'd5;
    localparam logic [3:0] S_BY  = 4'd6;
    localparam logic [3:0] S_BL  = 4'd7;
    localparam logic [3:0] S_BLY = 4'd8;
    localparam logic [3:0] S_RBA = 4'd9;

    // Light head encoding shared with the sensor-driven predecessor.
    localparam logic [1:0] LT_GREEN  = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_RED    = 2'b10;
    localparam logic [1:0] LT_LEFT   = 2'b11;

    // Terminal timer values, one less than the phase length.
    localparam logic [CNT_W-1:0] MIN_M1   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1   = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] LEFT_M1  = CNT_W'(LEFT_TIME - 1);
    localparam logic [CNT_W-1:0] ARED_M1  = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] tmr_q,   tmr_d;
    logic             pa_q,    pa_d;
    logic             pal_q,   pal_d;
    logic             pb_q,    pb_d;
    logic             pbl_q,   pbl_d;
    logic [1:0]       la_q,    la_d;
    logic [1:0]       lb_q,    lb_d;

    // Intermediate decisions
    logic             a_demand;
    logic             b_demand;
    logic             a_green_done;
    logic             b_green_done;
    logic             yel_done;
    logic             left_done;
    logic             ared_done;
    logic             state_chg;
    logic             tmr_sat;

    // Light decode for a state code; the result is {La, Lb}.
    function automatic logic [3:0] light_decode(input logic [3:0] s);
        logic [3:0] r;
        r = {LT_RED, LT_RED};
        case (s)
            S_AG:          r = {LT_GREEN,  LT_RED};
            S_AY, S_ALY:   r = {LT_YELLOW, LT_RED};
            S_AL:          r = {LT_LEFT,   LT_RED};
            S_RAB, S_RBA:  r = {LT_RED,    LT_RED};
            S_BG:          r = {LT_RED,    LT_GREEN};
            S_BY, S_BLY:   r = {LT_RED,    LT_YELLOW};
            S_BL:          r = {LT_RED,    LT_LEFT};
            default:       r = {LT_RED,    LT_RED};
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Green-exit conditions
    // ------------------------------------------------------------------
    // Demand seen by a green is anything pending that it is not serving:
    // the other street's straight and left, plus its own left turn.
    always_comb begin
        a_demand     = pb_q | pbl_q | pal_q;
        b_demand     = pa_q | pal_q | pbl_q;
        // Yield once min-green has elapsed if someone else waits and either
        // our own street has gone quiet or max-green has been reached.
        a_green_done = (tmr_q >= MIN_M1) && a_demand && (!Ta || (tmr_q == MAX_M1));
        b_green_done = (tmr_q >= MIN_M1) && b_demand && (!Tb || (tmr_q == MAX_M1));
        yel_done     = (tmr_q == YEL_M1);
        left_done    = (tmr_q == LEFT_M1);
        ared_done    = (tmr_q == ARED_M1);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_AG:  if (a_green_done) state_d = S_AY;
            // Left turn is only reachable through yellow, never from green.
            S_AY:  if (yel_done)     state_d = pal_q ? S_AL : S_RAB;
            S_AL:  if (left_done)    state_d = S_ALY;
            S_ALY: if (yel_done)     state_d = S_RAB;
            S_RAB: if (ared_done)    state_d = S_BG;
            S_BG:  if (b_green_done) state_d = S_BY;
            S_BY:  if (yel_done)     state_d = pbl_q ? S_BL : S_RBA;
            S_BL:  if (left_done)    state_d = S_BLY;
            S_BLY: if (yel_done)     state_d = S_RBA;
            S_RBA: if (ared_done)    state_d = S_AG;
            // Codes 10..15 recover to A green.
            default:                 state_d = S_AG;
        endcase
    end

    // ------------------------------------------------------------------
    // Phase timer: cleared on a phase change, otherwise saturating count
    // ------------------------------------------------------------------
    always_comb begin
        state_chg = (state_d != state_q);
        tmr_sat   = (tmr_q == MAX_M1);
        tmr_d     = tmr_q;
        if (state_chg) begin
            tmr_d = '0;
        end else if (!tmr_sat) begin
            tmr_d = tmr_q + TMR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Pending-demand flags
    // ------------------------------------------------------------------
    // A flag is not set while its phase is being served, and entering the
    // serving phase clears it (clear has priority over a same-edge set).
    always_comb begin
        pa_d  = pa_q  | (Ta  && (state_q != S_AG));
        pal_d = pal_q | (Tal && (state_q != S_AL));
        pb_d  = pb_q  | (Tb  && (state_q != S_BG));
        pbl_d = pbl_q | (Tbl && (state_q != S_BL));
        if ((state_d == S_AG) && (state_q != S_AG)) pa_d  = 1'b0;
        if ((state_d == S_AL) && (state_q != S_AL)) pal_d = 1'b0;
        if ((state_d == S_BG) && (state_q != S_BG)) pb_d  = 1'b0;
        if ((state_d == S_BL) && (state_q != S_BL)) pbl_d = 1'b0;
    end

    // ------------------------------------------------------------------
    // Light outputs: decode of the next state, registered alongside it so
    // La/Lb always reflect the current state register.
    // ------------------------------------------------------------------
    always_comb begin
        la_d = LT_RED;
        lb_d = LT_RED;
        {la_d, lb_d} = light_decode(state_d);
    end

    // ------------------------------------------------------------------
    // State register with synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_AG;
            tmr_q   <= '0;
            pa_q    <= 1'b0;
            pal_q   <= 1'b0;
            pb_q    <= 1'b0;
            pbl_q   <= 1'b0;
            la_q    <= LT_GREEN;
            lb_q    <= LT_RED;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pa_q    <= pa_d;
            pal_q   <= pal_d;
            pb_q    <= pb_d;
            pbl_q   <= pbl_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
        end
    end

    assign La    = la_q;
    assign Lb    = lb_q;
    assign phase = state_q;
    assign tmr   = tmr_q;

    // Conflicting greens must never be shown: one head is always red.
    a_lights_exclusive: assert property (
        @(posedge clk) disable iff (!reset_n)
        (la_q == LT_RED) || (lb_q == LT_RED)
    );

    // Once out of reset the state register only holds defined codes.
    a_state_legal: assert property (
        @(posedge clk) disable iff (!reset_n)
        state_q <= S_RBA
    );

endmodule

// File: tb/tb_tl_phase_sched.sv
// ---------------------------------------------------------------------------
// tb_tl_phase_sched
// Directed-vector bench for tl_phase_sched. Each phase run lists the light
// pattern, state code and starting timer value expected for a number of
// consecutive cycles; all values below were worked out by hand.
// ---------------------------------------------------------------------------
module tb_tl_phase_sched;

    localparam int unsigned MIN_GREEN = 4;
    localparam int unsigned MAX_GREEN = 10;
    localparam int unsigned YELLOW    = 2;
    localparam int unsigned LEFT_TIME = 3;
    localparam int unsigned ALL_RED   = 1;
    localparam int unsigned CNT_W     = 4;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] L = 2'b11;

    localparam logic [3:0] P_AG  = 4'd0;
    localparam logic [3:0] P_AY  = 4'd1;
    localparam logic [3:0] P_AL  = 4'd2;
    localparam logic [3:0] P_ALY = 4'd3;
    localparam logic [3:0] P_RAB = 4'd4;
    localparam logic [3:0] P_BG  = 4'd5;
    localparam logic [3:0] P_BY  = 4'd6;
    localparam logic [3:0] P_BL  = 4'd7;
    localparam logic [3:0] P_BLY = 4'd8;
    localparam logic [3:0] P_RBA = 4'd9;

    logic             clk;
    logic             reset_n;
    logic             Ta, Tal, Tb, Tbl;
    logic [1:0]       La, Lb;
    logic [3:0]       phase;
    logic [CNT_W-1:0] tmr;

    int n_cmp;
    int n_err;

    tl_phase_sched #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YELLOW    (YELLOW),
        .LEFT_TIME (LEFT_TIME),
        .ALL_RED   (ALL_RED),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Ta      (Ta),
        .Tal     (Tal),
        .Tb      (Tb),
        .Tbl     (Tbl),
        .La      (La),
        .Lb      (Lb),
        .phase   (phase),
        .tmr     (tmr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected $finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Hold reset for n edges, then check the reset state.
    task automatic apply_reset(input string tag, input int n);
        reset_n = 1'b0;
        Ta = 1'b0; Tal = 1'b0; Tb = 1'b0; Tbl = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check_val({tag, ".La"},    32'(La),    32'(G));
        check_val({tag, ".Lb"},    32'(Lb),    32'(R));
        check_val({tag, ".phase"}, 32'(phase), 32'(P_AG));
        check_val({tag, ".tmr"},   32'(tmr),   32'd0);
    endtask

    // n cycles in one phase; timer expected to start at t0 and saturate.
    task automatic run_phase(input string tag, input int n, input logic [1:0] la_e,
                             input logic [1:0] lb_e, input logic [3:0] ph_e, input int t0);
        for (int i = 0; i < n; i++) begin
            int te;
            @(posedge clk);
            #1;
            te = t0 + i;
            if (te > int'(MAX_GREEN) - 1) te = int'(MAX_GREEN) - 1;
            check_val($sformatf("%s.La[%0d]", tag, i),    32'(La),    32'(la_e));
            check_val($sformatf("%s.Lb[%0d]", tag, i),    32'(Lb),    32'(lb_e));
            check_val($sformatf("%s.phase[%0d]", tag, i), 32'(phase), 32'(ph_e));
            check_val($sformatf("%s.tmr[%0d]", tag, i),   32'(tmr),   32'(te));
            check_val($sformatf("%s.safe[%0d]", tag, i),
                      32'((La == R) || (Lb == R)), 32'd1);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        Ta = 1'b0; Tal = 1'b0; Tb = 1'b0; Tbl = 1'b0;

        // 1: idle after reset, A green held, timer saturates at 9
        apply_reset("t1_rst", 3);
        reset_n = 1'b1;
        run_phase("t1_idle", 20, G, R, P_AG, 1);

        // 2: single Tb pulse, B green held with no further demand
        apply_reset("t2_rst", 1);
        reset_n = 1'b1; Tb = 1'b1;
        run_phase("t2_ag",  1, G, R, P_AG, 1);
        Tb = 1'b0;
        run_phase("t2_ag",  2, G, R, P_AG, 2);
        run_phase("t2_ay",  2, Y, R, P_AY, 0);
        run_phase("t2_rab", 1, R, R, P_RAB, 0);
        run_phase("t2_bg", 12, R, G, P_BG, 0);

        // 3: Ta held -> max-green, then B yields at min-green to latched pa
        apply_reset("t3_rst", 1);
        reset_n = 1'b1; Ta = 1'b1; Tb = 1'b1;
        run_phase("t3_ag",  1, G, R, P_AG, 1);
        Tb = 1'b0;
        run_phase("t3_ag",  8, G, R, P_AG, 2);
        run_phase("t3_ay",  2, Y, R, P_AY, 0);
        run_phase("t3_rab", 1, R, R, P_RAB, 0);
        run_phase("t3_bg",  4, R, G, P_BG, 0);
        run_phase("t3_by",  2, R, Y, P_BY, 0);
        run_phase("t3_rba", 1, R, R, P_RBA, 0);
        run_phase("t3_ag2", 3, G, R, P_AG, 0);
        Ta = 1'b0;

        // 4: A left turn served, then pal must be gone on the next A cycle
        apply_reset("t4_rst", 1);
        reset_n = 1'b1; Tal = 1'b1; Tb = 1'b1;
        run_phase("t4_ag",  1, G, R, P_AG, 1);
        Tal = 1'b0; Tb = 1'b0;
        run_phase("t4_ag",  2, G, R, P_AG, 2);
        run_phase("t4_ay",  2, Y, R, P_AY, 0);
        run_phase("t4_al",  3, L, R, P_AL, 0);
        run_phase("t4_aly", 2, Y, R, P_ALY, 0);
        run_phase("t4_rab", 1, R, R, P_RAB, 0);
        run_phase("t4_bg",  4, R, G, P_BG, 0);
        Ta = 1'b1;
        run_phase("t4_bg",  1, R, G, P_BG, 4);
        Ta = 1'b0;
        run_phase("t4_by",  2, R, Y, P_BY, 0);
        run_phase("t4_rba", 1, R, R, P_RBA, 0);
        run_phase("t4_ag2", 1, G, R, P_AG, 0);
        Tb = 1'b1;
        run_phase("t4_ag2", 1, G, R, P_AG, 1);
        Tb = 1'b0;
        run_phase("t4_ag2", 2, G, R, P_AG, 2);
        run_phase("t4_ay2", 2, Y, R, P_AY, 0);
        run_phase("t4_rab2",1, R, R, P_RAB, 0);
        run_phase("t4_bg2", 2, R, G, P_BG, 0);

        // 5: only Tbl -> A left skipped, B left served
        apply_reset("t5_rst", 1);
        reset_n = 1'b1; Tbl = 1'b1;
        run_phase("t5_ag",  1, G, R, P_AG, 1);
        Tbl = 1'b0;
        run_phase("t5_ag",  2, G, R, P_AG, 2);
        run_phase("t5_ay",  2, Y, R, P_AY, 0);
        run_phase("t5_rab", 1, R, R, P_RAB, 0);
        run_phase("t5_bg",  4, R, G, P_BG, 0);
        run_phase("t5_by",  2, R, Y, P_BY, 0);
        run_phase("t5_bl",  3, R, L, P_BL, 0);
        run_phase("t5_bly", 2, R, Y, P_BLY, 0);
        run_phase("t5_rba", 1, R, R, P_RBA, 0);
        run_phase("t5_ag2", 3, G, R, P_AG, 0);

        // 6: reset in the middle of B left with pb pending
        apply_reset("t6_rst0", 1);
        reset_n = 1'b1; Tbl = 1'b1;
        run_phase("t6_ag",  1, G, R, P_AG, 1);
        Tbl = 1'b0;
        run_phase("t6_ag",  2, G, R, P_AG, 2);
        run_phase("t6_ay",  2, Y, R, P_AY, 0);
        run_phase("t6_rab", 1, R, R, P_RAB, 0);
        run_phase("t6_bg",  4, R, G, P_BG, 0);
        run_phase("t6_by",  2, R, Y, P_BY, 0);
        run_phase("t6_bl",  1, R, L, P_BL, 0);
        Tb = 1'b1;
        run_phase("t6_bl",  1, R, L, P_BL, 1);
        apply_reset("t6_rst", 1);
        reset_n = 1'b1;
        // Any surviving pending flag would force A to yield at tmr 3.
        run_phase("t6_hold", 10, G, R, P_AG, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
